cc_regbank_read_arbiter: RTL
============================

Name: cc_regbank_read_arbiter

Overview:
- Shares the single 16-entry register-bank read mux between two requesters and sequences each read.
- Requester 0 is the datapath microcontrol; requester 1 is the debug/monitor port.
- Drives the 6-bit mux select, captures the selected 32-bit word one cycle later, and returns it with a per-requester response pulse.
- Uses round-robin arbitration and valid/ready request handshakes.

Parameters:
- DATAWIDTH_MIR_DIRECTION, 6, width of register address / mux select.
- DATAWIDTH_BUS, 32, width of read data.
- NUM_REGS, 16, number of valid register addresses (0..NUM_REGS-1).

Ports:
- CC_REGARB_CLOCK_50  in  1  single system clock, rising edge.
- CC_REGARB_RESET_InHigh  in  1  reset, synchronous, active-high.
- CC_REGARB_req0Valid_In  in  1  requester 0 read request.
- CC_REGARB_req0Addr_InBus  in  DATAWIDTH_MIR_DIRECTION  requester 0 register address.
- CC_REGARB_req0Ready_Out  out  1  requester 0 request accepted this cycle.
- CC_REGARB_rsp0Valid_Out  out  1  requester 0 response pulse.
- CC_REGARB_req1Valid_In  in  1  requester 1 read request.
- CC_REGARB_req1Addr_InBus  in  DATAWIDTH_MIR_DIRECTION  requester 1 register address.
- CC_REGARB_req1Ready_Out  out  1  requester 1 request accepted this cycle.
- CC_REGARB_rsp1Valid_Out  out  1  requester 1 response pulse.
- CC_REGARB_rspData_OutBus  out  DATAWIDTH_BUS  captured read data, shared by both requesters.
- CC_REGARB_muxAddress_OutBus  out  DATAWIDTH_MIR_DIRECTION  select to the register-bank mux.
- CC_REGARB_muxData_InBus  in  DATAWIDTH_BUS  mux output (combinational from select).
- CC_REGARB_busy_Out  out  1  high when state is not IDLE.

Behaviour:
- Clocking and reset: one clock; reset is synchronous and active-high. All state updates happen on the rising edge of CC_REGARB_CLOCK_50.
- Reset values:
  - state = IDLE.
  - muxAddress = 0.
  - rspData = 0.
  - rsp0Valid = rsp1Valid = 0.
  - busy = 0.
  - lastGrant = 1, so requester 0 wins the first contention.
  - req0Ready and req1Ready are forced 0 while reset is high.
- States:
  - IDLE: no transaction in flight.
  - ADDR: select is being driven to the mux.
  - RESP: data has been captured and the response pulse is high.
- Accept window:
  - Requests are accepted only in IDLE or RESP.
  - readyN is combinational and asserted only for the granted requester in an accept state.
  - An accept is reqNValid & reqNReady in the same cycle.
- Arbitration:
  - Only one requester valid: it is granted.
  - Both valid: grant !lastGrant.
  - lastGrant updates to the winner on each accept.
  - The loser's ready stays 0; it must hold valid and address stable until accepted.
- Transition on accept at edge T:
  - muxAddress <= reqAddr of the winner; owner <= winner; state -> ADDR.
  - During cycle T+1, the mux select is stable. At edge T+1: rspData <= muxData, rspNValid <= 1 for the owner, state -> RESP.
  - During T+2, rspNValid = 1 and rspData is valid.
  - Fixed latency: accept edge to response cycle = 2 cycles.
- RESP exit:
  - Accept in RESP -> ADDR (back-to-back; throughput one read per 2 cycles).
  - No accept in RESP -> IDLE.
- Response pulses: rspNValid is high for exactly one cycle. rsp0Valid and rsp1Valid are never high together.
- Data hold: rspData holds its value until the next capture; it is not cleared on return to IDLE.
- muxAddress hold: muxAddress holds its last value in IDLE.
- busy = (state != IDLE).
- Reset mid-operation:
  - A transaction in ADDR or RESP is dropped; no response pulse is issued after reset.
  - A request pending at reset deassertion is re-arbitrated from IDLE with lastGrant = 1.
- Address range: addresses >= NUM_REGS are passed through unchanged, and the mux default returns entry 0 (unless the optional feature below is compiled in).

Optional Feature:
- Macro: CC_REGARB_RANGE_CHECK_EN.
- With it defined:
  - An accepted address >= NUM_REGS is replaced by 0 on muxAddress.
  - An extra output CC_REGARB_rangeErr_Out pulses high in the same cycle as the owner's rspNValid.
  - rangeErr resets to 0.
- Without it: the rangeErr port does not exist, and addresses are forwarded unmodified.

Test Plan:
- Single read: reset 2 cycles; muxData modelled as 0x1000_0000+addr; req0 addr=5 at cycle 0 -> ready0=1 cycle 0, muxAddress=5 cycle 1, rsp0Valid=1 and rspData=0x1000_0005 cycle 2, busy=0 cycle 3.
- Contention round-robin: req0 addr=3 and req1 addr=9 both held valid from IDLE -> req0 accepted first, then req1 in the following RESP cycle; rsp0 data 0x1000_0003, then rsp1 data 0x1000_0009 two cycles later.
- Back-to-back fairness: req0 and req1 continuously valid for 8 cycles -> grants alternate 0,1,0,1; one rsp pulse every 2 cycles; never both rspValid high together.
- Reset mid-op: req1 addr=7 accepted, reset asserted in the ADDR cycle for 1 cycle -> no rsp1Valid, rspData=0, state IDLE, muxAddress=0.
- Out of range: req0 addr=20.
  - Without the macro: muxAddress=20 and rspData = model(20) = 0x1000_0014.
  - With CC_REGARB_RANGE_CHECK_EN defined: muxAddress=0, rspData=0x1000_0000, and rangeErr=1 with rsp0Valid.
- Loser stability: req1 valid with addr=2 while req0 holds the grant -> ready1=0 until accepted; the eventual response returns 0x1000_0002.

Source files
------------

// File: rtl/cc_regbank_read_arbiter.sv
// cc_regbank_read_arbiter
// Shares the 16-entry register-bank read mux between the datapath
// microcontrol (requester 0) and the debug/monitor port (requester 1).
// Each accepted request drives the mux select for one cycle, captures the
// selected word on the following edge and returns it with a one-cycle
// response pulse to the owner. Round-robin arbitration between the two.
//
// Ports:
//   CC_REGARB_CLOCK_50           rising-edge system clock
//   CC_REGARB_RESET_InHigh       synchronous active-high reset
//   CC_REGARB_req{0,1}Valid_In   read request from requester 0/1
//   CC_REGARB_req{0,1}Addr_InBus register address from requester 0/1
//   CC_REGARB_req{0,1}Ready_Out  request accepted this cycle (combinational)
//   CC_REGARB_rsp{0,1}Valid_Out  one-cycle response pulse to requester 0/1
//   CC_REGARB_rspData_OutBus     captured read data, shared by both requesters
//   CC_REGARB_muxAddress_OutBus  select to the register-bank mux
//   CC_REGARB_muxData_InBus      mux output, combinational from the select
//   CC_REGARB_busy_Out           high while a read is in flight
//   CC_REGARB_rangeErr_Out       (CC_REGARB_RANGE_CHECK_EN only) pulses with
//                                the response of an out-of-range address
//
// Optional feature macro: CC_REGARB_RANGE_CHECK_EN
//   When defined, addresses >= NUM_REGS are replaced by 0 on the mux select
//   and flagged on CC_REGARB_rangeErr_Out. When undefined, addresses pass
//   through unchanged and the rangeErr port does not exist.

module cc_regbank_read_arbiter #(
   parameter int unsigned DATAWIDTH_MIR_DIRECTION = 6,
   parameter int unsigned DATAWIDTH_BUS           = 32,
   parameter int unsigned NUM_REGS                = 16
) (
   input  logic                               CC_REGARB_CLOCK_50,
   input  logic                               CC_REGARB_RESET_InHigh,
   input  logic                               CC_REGARB_req0Valid_In,
   input  logic [DATAWIDTH_MIR_DIRECTION-1:0] CC_REGARB_req0Addr_InBus,
   output logic                               CC_REGARB_req0Ready_Out,
   output logic                               CC_REGARB_rsp0Valid_Out,
   input  logic                               CC_REGARB_req1Valid_In,
   input  logic [DATAWIDTH_MIR_DIRECTION-1:0] CC_REGARB_req1Addr_InBus,
   output logic                               CC_REGARB_req1Ready_Out,
   output logic                               CC_REGARB_rsp1Valid_Out,
   output logic [DATAWIDTH_BUS-1:0]           CC_REGARB_rspData_OutBus,
   output logic [DATAWIDTH_MIR_DIRECTION-1:0] CC_REGARB_muxAddress_OutBus,
   input  logic [DATAWIDTH_BUS-1:0]           CC_REGARB_muxData_InBus,
   output logic                               CC_REGARB_busy_Out
`ifdef CC_REGARB_RANGE_CHECK_EN
   ,
   output logic                               CC_REGARB_rangeErr_Out
`endif
);

`ifdef CC_REGARB_RANGE_CHECK_EN
   localparam bit rangeCheckEn = 1'b1;
`else
   localparam bit rangeCheckEn = 1'b0;
`endif

   localparam logic [DATAWIDTH_MIR_DIRECTION-1:0] lastRegLimit =
      DATAWIDTH_MIR_DIRECTION'(NUM_REGS);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      ADDR = 2'd1,
      RESP = 2'd2
   } arbState_t;

   arbState_t state;
   logic      lastGrant;   // 1 = requester 1 won the most recent accept
   logic      owner;       // requester of the read currently in flight

   logic                               acceptWindow;
   logic                               grant0;
   logic                               grant1;
   logic                               accept;
   logic                               winner;
   logic [DATAWIDTH_MIR_DIRECTION-1:0] winnerAddr;
   logic                               outOfRange;
   logic [DATAWIDTH_MIR_DIRECTION-1:0] selAddr;

`ifdef CC_REGARB_RANGE_CHECK_EN
   logic errPending;       // out-of-range flag carried from accept to response
`endif

   // Round-robin grant: a lone requester wins, contention goes to !lastGrant.
   always_comb begin
      acceptWindow = (state == IDLE) || (state == RESP);
      grant0       = CC_REGARB_req0Valid_In & (~CC_REGARB_req1Valid_In | lastGrant);
      grant1       = CC_REGARB_req1Valid_In & (~CC_REGARB_req0Valid_In | ~lastGrant);
      accept       = acceptWindow & ~CC_REGARB_RESET_InHigh & (grant0 | grant1);
      winner       = grant1;
      winnerAddr   = grant1 ? CC_REGARB_req1Addr_InBus : CC_REGARB_req0Addr_InBus;
      outOfRange   = (winnerAddr >= lastRegLimit);
      selAddr      = (rangeCheckEn && outOfRange) ? '0 : winnerAddr;
   end

   assign CC_REGARB_req0Ready_Out = ~CC_REGARB_RESET_InHigh & acceptWindow & grant0;
   assign CC_REGARB_req1Ready_Out = ~CC_REGARB_RESET_InHigh & acceptWindow & grant1;
   assign CC_REGARB_busy_Out      = (state != IDLE);

   // Read sequencer: accept -> ADDR (select stable) -> RESP (capture + pulse).
   always_ff @(posedge CC_REGARB_CLOCK_50) begin
      if (CC_REGARB_RESET_InHigh) begin
         state                       <= IDLE;
         lastGrant                   <= 1'b1;
         owner                       <= 1'b0;
         CC_REGARB_muxAddress_OutBus <= '0;
         CC_REGARB_rspData_OutBus    <= '0;
         CC_REGARB_rsp0Valid_Out     <= 1'b0;
         CC_REGARB_rsp1Valid_Out     <= 1'b0;
`ifdef CC_REGARB_RANGE_CHECK_EN
         errPending                  <= 1'b0;
         CC_REGARB_rangeErr_Out      <= 1'b0;
`endif
      end else begin
         CC_REGARB_rsp0Valid_Out <= 1'b0;
         CC_REGARB_rsp1Valid_Out <= 1'b0;
`ifdef CC_REGARB_RANGE_CHECK_EN
         CC_REGARB_rangeErr_Out  <= 1'b0;
`endif
         unique case (state)
            IDLE, RESP: begin
               if (accept) begin
                  CC_REGARB_muxAddress_OutBus <= selAddr;
                  owner                       <= winner;
                  lastGrant                   <= winner;
                  state                       <= ADDR;
`ifdef CC_REGARB_RANGE_CHECK_EN
                  errPending                  <= outOfRange;
`endif
               end else begin
                  state <= IDLE;
               end
            end
            ADDR: begin
               CC_REGARB_rspData_OutBus <= CC_REGARB_muxData_InBus;
               CC_REGARB_rsp0Valid_Out  <= ~owner;
               CC_REGARB_rsp1Valid_Out  <= owner;
               state                    <= RESP;
`ifdef CC_REGARB_RANGE_CHECK_EN
               CC_REGARB_rangeErr_Out   <= errPending;
`endif
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule
